// File: rtl/fib_pkg.sv
// Shared constants and types for the FIB <-> SPI byte path.
// Contents: field widths, packet byte counts, transmitter state type.
package fib_pkg;
  localparam int PREFIX_W       = 64;
  localparam int META_W         = 8;
  localparam int DATA_W         = 256;

  localparam int INTEREST_BYTES = (META_W + PREFIX_W) / 8;           // 9
  localparam int DATA_BYTES     = (META_W + PREFIX_W + DATA_W) / 8;  // 41

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } fib_tx_state_t;
endpackage

// File: rtl/fib_spi_tx.sv
// fib_spi_tx: byte-serial transmitter, FIB -> SPI.
// Takes one interest ({metadata, prefix}) or data ({metadata, prefix, data})
// packet in parallel and streams it MSB byte first, one byte per accepted beat.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   pkt_valid/pkt_ready      packet handshake (ready = transmitter idle)
//   pkt_is_data              1 = data packet, 0 = interest packet
//   pkt_metadata/prefix/data packet fields (data ignored for interest)
//   TX_ready                 SPI side takes the presented byte this cycle
//   FIB_to_SPI_data_flag     data_FIB_to_SPI holds a valid byte
//   data_FIB_to_SPI          current byte (00 when flag is low)
//   tx_last                  current byte is the final one of the packet
//   tx_done                  one-cycle pulse after the final byte is taken
module fib_spi_tx
  import fib_pkg::*;
#(
  parameter int PREFIX_W = fib_pkg::PREFIX_W,
  parameter int META_W   = fib_pkg::META_W,
  parameter int DATA_W   = fib_pkg::DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pkt_valid,
  input  logic                pkt_is_data,
  input  logic [META_W-1:0]   pkt_metadata,
  input  logic [PREFIX_W-1:0] pkt_prefix,
  input  logic [DATA_W-1:0]   pkt_data,
  output logic                pkt_ready,
  input  logic                TX_ready,
  output logic                FIB_to_SPI_data_flag,
  output logic [7:0]          data_FIB_to_SPI,
  output logic                tx_last,
  output logic                tx_done
);

  localparam int SR_W      = META_W + PREFIX_W + DATA_W;
  localparam int INT_BYTES = (META_W + PREFIX_W) / 8;
  localparam int ALL_BYTES = SR_W / 8;

  fib_tx_state_t state, state_nxt;
  logic [SR_W-1:0] sr;
  logic [5:0]      cnt;

  logic byte_take;
  assign byte_take = (state == SEND) && TX_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && pkt_valid) begin
        // Left-aligned: an interest leaves the payload slot zero and simply
        // stops after its 9 bytes.
        sr  <= pkt_is_data ? {pkt_metadata, pkt_prefix, pkt_data}
                           : {pkt_metadata, pkt_prefix, {DATA_W{1'b0}}};
        cnt <= pkt_is_data ? 6'(ALL_BYTES) : 6'(INT_BYTES);
      end else if (byte_take && cnt != '0) begin
        sr  <= {sr[SR_W-9:0], 8'h00};
        cnt <= cnt - 6'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pkt_valid) state_nxt = SEND;
      SEND:    if (byte_take && cnt == 6'd1) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // All outputs are pure decodes of registered state, so nothing here
  // depends combinationally on TX_ready or pkt_valid.
  always_comb begin
    pkt_ready            = 1'b0;
    FIB_to_SPI_data_flag = 1'b0;
    data_FIB_to_SPI      = 8'h00;
    tx_last              = 1'b0;
    tx_done              = 1'b0;
    case (state)
      IDLE: pkt_ready = 1'b1;
      SEND: begin
        FIB_to_SPI_data_flag = 1'b1;
        data_FIB_to_SPI      = sr[SR_W-1 -: 8];
        tx_last              = (cnt == 6'd1);
      end
      DONE: tx_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fib_spi_tx.sv
// Self-checking bench for fib_spi_tx: a vector table of packets (with stall
// and busy-offer columns) driven through a common task, a byte scoreboard,
// plus hand-written sequences for exact cycle timing and mid-packet reset.
module tb_fib_spi_tx;
  logic         clk = 1'b0;
  logic         rst;
  logic         pkt_valid;
  logic         pkt_is_data;
  logic [7:0]   pkt_metadata;
  logic [63:0]  pkt_prefix;
  logic [255:0] pkt_data;
  logic         pkt_ready;
  logic         TX_ready;
  logic         flag;
  logic [7:0]   data;
  logic         tx_last;
  logic         tx_done;

  fib_spi_tx dut (
    .clk(clk), .rst(rst),
    .pkt_valid(pkt_valid), .pkt_is_data(pkt_is_data),
    .pkt_metadata(pkt_metadata), .pkt_prefix(pkt_prefix), .pkt_data(pkt_data),
    .pkt_ready(pkt_ready), .TX_ready(TX_ready),
    .FIB_to_SPI_data_flag(flag), .data_FIB_to_SPI(data),
    .tx_last(tx_last), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] b;
    logic       last;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    logic         is_data;
    logic [7:0]   meta;
    logic [63:0]  prefix;
    logic [255:0] pdata;
    int           stall_byte;  // 1-based byte to stall on, 0 = none
    int           stall_cyc;
    bit           poke;        // offer a second packet while busy
    int           exp_flag;    // expected flag-high cycles
    int           exp_done;    // expected tx_done cycle after accept edge
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_pkt(input logic is_data, input logic [7:0] meta,
                          input logic [63:0] prefix, input logic [255:0] pdata);
    logic [327:0] v;
    int n;
    sb_t e;
    v = {meta, prefix, pdata};
    n = is_data ? 41 : 9;
    for (int i = 0; i < n; i++) begin
      e.b    = v[327-8*i -: 8];
      e.last = (i == n-1);
      sbq.push_back(e);
    end
  endtask

  // Scoreboard: every byte the SPI side takes must be the next expected one.
  always @(negedge clk) begin
    sb_t e;
    if (!rst && flag && TX_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_byte: got %02h expected none", data);
      end else begin
        e = sbq.pop_front();
        chk("byte", data, e.b);
        chk("tx_last", tx_last, e.last);
      end
    end
  end

  task automatic offer(input vec_t v);
    pkt_valid    = 1'b1;
    pkt_is_data  = v.is_data;
    pkt_metadata = v.meta;
    pkt_prefix   = v.prefix;
    pkt_data     = v.pdata;
    push_pkt(v.is_data, v.meta, v.prefix, v.pdata);
    @(posedge clk); #1;
    pkt_valid = 1'b0;
  endtask

  task automatic run(input vec_t v);
    int acc, fc, dc, left, bad_ready;
    acc = 0; fc = 0; dc = 0; left = v.stall_cyc; bad_ready = 0;
    offer(v);
    for (int k = 1; k <= 200 && dc == 0; k++) begin
      TX_ready = !(acc == v.stall_byte - 1 && left > 0);
      if (!TX_ready) left--;
      if (v.poke && k >= 2 && k <= 5) begin
        pkt_valid    = 1'b1;
        pkt_is_data  = 1'b1;
        pkt_metadata = 8'hEE;
        pkt_prefix   = 64'hDEADBEEFDEADBEEF;
      end else begin
        pkt_valid = 1'b0;
      end
      @(negedge clk);
      if (flag) fc++;
      if (flag && TX_ready) acc++;
      if (pkt_ready) bad_ready++;
      if (tx_done) dc = k;
      @(posedge clk); #1;
    end
    pkt_valid = 1'b0;
    TX_ready  = 1'b1;
    chk("flag_cycles", fc, v.exp_flag);
    chk("done_cycle", dc, v.exp_done);
    chk("ready_low_busy", bad_ready, 0);
    @(negedge clk);
    chk("ready_after", pkt_ready, 1'b1);
    chk("flag_after", flag, 1'b0);
    chk("data_after", data, 8'h00);
    chk("done_after", tx_done, 1'b0);
    @(posedge clk); #1;
  endtask

  vec_t vt[6];
  logic [255:0] asc;
  logic [7:0]   lit[9];

  initial begin
    for (int i = 0; i < 32; i++) asc[255-8*i -: 8] = 8'h10 + 8'(i);
    lit = '{8'h30, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF};

    vt[0] = '{1'b0, 8'd48, 64'h0000FFFF0000FFFF, '0, 0, 0, 1'b0, 9, 10};
    vt[1] = '{1'b1, 8'hA5, 64'h0102030405060708, asc, 0, 0, 1'b0, 41, 42};
    vt[2] = '{1'b0, 8'd48, 64'h0000FFFF0000FFFF, '0, 4, 3, 1'b0, 12, 13};
    vt[3] = '{1'b0, 8'd48, 64'h0000FFFF0000FFFF, '0, 0, 0, 1'b1, 9, 10};
    vt[4] = '{1'b1, 8'hC3, 64'h1122334455667788,
              256'hF0E1D2C3B4A5968778695A4B3C2D1E0F00112233445566778899AABBCCDDEEFF,
              41, 2, 1'b0, 43, 44};
    vt[5] = '{1'b0, 8'h00, 64'h8000000000000001, '0, 1, 5, 1'b0, 14, 15};

    rst = 1'b1; pkt_valid = 1'b0; pkt_is_data = 1'b0; pkt_metadata = '0;
    pkt_prefix = '0; pkt_data = '0; TX_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", pkt_ready, 1'b1);
    chk("rst_flag", flag, 1'b0);
    chk("rst_data", data, 8'h00);
    chk("rst_last", tx_last, 1'b0);
    chk("rst_done", tx_done, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Exact per-cycle interest stream against literal bytes.
    offer(vt[0]);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk("lit_flag", flag, 1'b1);
      chk("lit_byte", data, lit[k-1]);
      chk("lit_last", tx_last, k == 9);
      chk("lit_ready", pkt_ready, 1'b0);
    end
    @(negedge clk);
    chk("lit_done", tx_done, 1'b1);
    chk("lit_done_flag", flag, 1'b0);
    chk("lit_done_ready", pkt_ready, 1'b0);
    @(negedge clk);
    chk("lit_ready_back", pkt_ready, 1'b1);
    chk("lit_done_gone", tx_done, 1'b0);
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      run(vt[i]);
      repeat (2) begin
        @(negedge clk);
        chk("idle_flag", flag, 1'b0);
        @(posedge clk); #1;
      end
    end

    // Reset in the middle of a data packet, after byte 5 is taken.
    offer(vt[1]);
    repeat (5) begin
      @(negedge clk);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    TX_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    TX_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_flag", flag, 1'b0);
    chk("mid_rst_ready", pkt_ready, 1'b1);
    chk("mid_rst_data", data, 8'h00);
    chk("mid_rst_last", tx_last, 1'b0);
    chk("mid_rst_done", tx_done, 1'b0);
    chk("mid_rst_sb_left", sbq.size(), 36);
    sbq.delete();
    begin
      int dones;
      dones = 0;
      repeat (5) begin
        @(posedge clk); #1;
        @(negedge clk);
        if (tx_done) dones++;
      end
      chk("mid_rst_no_done", dones, 0);
    end
    @(posedge clk); #1;
    run(vt[0]);

    chk("sb_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
